writeback: RTL
==============

// Module: writeback
// PURPOSE
// - Final (5th) pipeline stage. Consumes memacc outputs, drives the decode-stage regfile write port.
// - Selects the result (ALU / load / link PC) and sign/zero-extends sub-word loads.
// - Holds a 1-entry bypass register of the last retired write for decode-side RAW forwarding.
// - Keeps retire/cycle counters and a sticky misaligned-load error flag.
// PARAMETERS
// - XLEN      32  datapath width
// - CNT_W     64  width of cycle_count / instret_count
// PORTS
// - clk                 in   1      rising-edge clock
// - rst                 in   1      synchronous reset, active-high
// - valid_in            in   1      memacc slot holds a real instruction (0 = bubble)
// - res_src_in          in   2      00 exec, 01 mem (load), 10 next_pc (link), 11 reserved
// - load_type_in        in   3      RV32I funct3 of load: 000 LB,001 LH,010 LW,100 LBU,101 LHU
// - exec_data_in        in   XLEN   ALU result; [1:0] = load byte offset when res_src=01
// - mem_data_in         in   XLEN   raw aligned memory word
// - next_pc_in          in   XLEN   pc+4 for JAL/JALR link
// - rd_write_enable_in  in   1      instruction writes rd
// - rd_write_addr_in    in   5      rd index
// - reg_write_data      out  XLEN   to decode.reg_write_data
// - reg_write_enable    out  1      to decode.reg_write_enable
// - reg_write_addr      out  5      to decode.reg_write_addr
// - fwd_valid           out  1      bypass register holds a live write
// - fwd_addr            out  5      bypass rd index
// - fwd_data            out  XLEN   bypass value
// - cycle_count         out  CNT_W  cycles since reset
// - instret_count       out  CNT_W  retired (valid, non-faulting) instructions
// - misaligned_err      out  1      sticky: a misaligned load reached writeback
// BEHAVIOUR
// - Write port combinational, 0-cycle latency: regfile captures on same posedge.
// - Result: 00 -> exec_data_in; 10 -> next_pc_in; 11 -> 0; 01 -> extended load:
//   - LB/LBU: byte mem_data_in[8*off+:8], sign/zero ext; off = exec_data_in[1:0].
//   - LH/LHU: half mem_data_in[16*off[1]+:16]; off[0]=1 misaligned.
//   - LW: whole word; off!=0 misaligned. Other load_type -> treated as LW.
// - fault = valid_in & res_src_in==01 & misaligned.
// - reg_write_enable = valid_in & rd_write_enable_in & (rd_write_addr_in!=0) & ~fault.
// - reg_write_addr / reg_write_data passed through regardless; only enable gates.
// - Bypass reg (posedge): if reg_write_enable -> fwd_valid=1, fwd_addr/data = write port;
//   else hold. Same-cycle write to same rd overwrites (newest wins).
// - cycle_count += 1 every cycle; wraps 2^CNT_W-1 -> 0, no flag.
// - instret_count += 1 when valid_in & ~fault (rd-less instructions and x0 writes count); wraps.
// - misaligned_err set on fault, cleared only by rst.
// - rst (any cycle, incl. mid-stream): next edge fwd_valid=0, fwd_addr=0, fwd_data=0,
//   cycle_count=0, instret_count=0, misaligned_err=0. While rst=1,
//   reg_write_enable forced 0 and counters do not increment.
// - valid_in=0: no write, no retire; bypass and flag hold.
// TESTING
// - rst 1 cycle, then 3 bubbles -> cycle_count=3, instret=0, fwd_valid=0, reg_write_enable=0.
// - LB off=3, mem=0x80FF_1234 -> data 0xFFFF_FF80; LBU same -> 0x0000_0080; LHU off=2 -> 0x0000_80FF.
// - LH off=1, rd=5 -> reg_write_enable=0, misaligned_err=1 next edge and stays; instret unchanged.
// - JAL rd=1 next_pc=0x104 -> write x1=0x104; next cycle fwd_valid=1,fwd_addr=1,fwd_data=0x104.
// - ALU write rd=0 value 0xDEAD -> reg_write_enable=0, bypass unchanged, instret +1.
// - Preload cycle_count=2^64-1 via long run/force -> next edge 0; rst mid-stream clears all state.

Source files
------------

// File: rtl/writeback.sv
// Final pipeline stage: selects and extends the retiring result, drives the regfile write port,
// and keeps the bypass register, retire/cycle counters and the sticky misaligned-load flag.
module writeback #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [1:0]       res_src_in,
    input  logic [2:0]       load_type_in,
    input  logic [XLEN-1:0]  exec_data_in,
    input  logic [XLEN-1:0]  mem_data_in,
    input  logic [XLEN-1:0]  next_pc_in,
    input  logic             rd_write_enable_in,
    input  logic [4:0]       rd_write_addr_in,
    output logic [XLEN-1:0]  reg_write_data,
    output logic             reg_write_enable,
    output logic [4:0]       reg_write_addr,
    output logic             fwd_valid,
    output logic [4:0]       fwd_addr,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count,
    output logic             misaligned_err
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]      w_off;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_result;
    logic            w_misaligned;
    logic            w_fault;
    logic            w_retire;
    logic            w_wen;

    logic             r_fwd_valid;
    logic [4:0]       r_fwd_addr;
    logic [XLEN-1:0]  r_fwd_data;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_instret;
    logic             r_err;

    always_comb begin
        w_off = exec_data_in[1:0];
        case (w_off)
            2'd0:    w_byte = mem_data_in[7:0];
            2'd1:    w_byte = mem_data_in[15:8];
            2'd2:    w_byte = mem_data_in[23:16];
            default: w_byte = mem_data_in[31:24];
        endcase
        w_half = w_off[1] ? mem_data_in[31:16] : mem_data_in[15:0];

        w_load       = mem_data_in;
        w_misaligned = 1'b0;
        // Unlisted funct3 encodings fall through to word semantics
        case (load_type_in)
            3'b000: w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100: w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b001: begin
                w_load       = {{(XLEN-16){w_half[15]}}, w_half};
                w_misaligned = w_off[0];
            end
            3'b101: begin
                w_load       = {{(XLEN-16){1'b0}}, w_half};
                w_misaligned = w_off[0];
            end
            default: begin
                w_load       = mem_data_in;
                w_misaligned = |w_off;
            end
        endcase

        case (res_src_in)
            2'b00:   w_result = exec_data_in;
            2'b01:   w_result = w_load;
            2'b10:   w_result = next_pc_in;
            default: w_result = '0;
        endcase

        w_fault  = valid_in & (res_src_in == 2'b01) & w_misaligned;
        w_retire = valid_in & ~w_fault;
        w_wen    = w_retire & rd_write_enable_in & (|rd_write_addr_in) & ~rst;
    end

    assign reg_write_data   = w_result;
    assign reg_write_addr   = rd_write_addr_in;
    assign reg_write_enable = w_wen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
            r_cycle     <= '0;
            r_instret   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_cycle <= r_cycle + CNT_ONE;
            if (w_retire)
                r_instret <= r_instret + CNT_ONE;
            if (w_fault)
                r_err <= 1'b1;
            if (w_wen) begin
                r_fwd_valid <= 1'b1;
                r_fwd_addr  <= rd_write_addr_in;
                r_fwd_data  <= w_result;
            end
        end
    end

    assign fwd_valid      = r_fwd_valid;
    assign fwd_addr       = r_fwd_addr;
    assign fwd_data       = r_fwd_data;
    assign cycle_count    = r_cycle;
    assign instret_count  = r_instret;
    assign misaligned_err = r_err;
endmodule
